// File: rtl/dbnc_pkg.sv
// Shared definitions for the time-shared button debouncer: FSM encoding and defaults.
package dbnc_pkg;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_REPORT = 2'd2
    } dbnc_state_e;

    localparam int DEFAULT_N_BTN         = 4;
    localparam int DEFAULT_STABLE_CYCLES = 8;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one raw button level, cleared by the synchronous reset.
module btn_sync (
    input  logic ck,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Double-register the asynchronous input into the ck domain
    always_ff @(posedge ck) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Round-robin debouncer: one settle counter shared by all buttons, confirmed
// presses produce a single-clock push pulse.
module debounce_scan_ctrl #(
    parameter int N_BTN         = dbnc_pkg::DEFAULT_N_BTN,
    parameter int STABLE_CYCLES = dbnc_pkg::DEFAULT_STABLE_CYCLES
) (
    input  logic             ck,
    input  logic             reset,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] push,
    output logic [N_BTN-1:0] level,
    output logic             busy
);

    import dbnc_pkg::*;

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int PTR_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [N_BTN-1:0] bsync_s;
    logic [N_BTN-1:0] mismatch_s;
    logic [PTR_W-1:0] pick_s;

    dbnc_state_e      state_r;
    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] sel_r;
    logic             cand_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N_BTN-1:0] level_r;
    logic [N_BTN-1:0] push_r;

    // First mismatching index, searching ptr, ptr+1, ... with wrap
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_BTN-1:0] m,
                                                 input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        logic             found;
        int               idx;
        r     = p;
        found = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            idx = (int'(p) + i) % N_BTN;
            if (!found && m[idx]) begin
                r     = PTR_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        logic [PTR_W-1:0] r;
        if (int'(i) >= N_BTN - 1) begin
            r = '0;
        end else begin
            r = i + PTR_W'(1);
        end
        return r;
    endfunction

    for (genvar g = 0; g < N_BTN; g++) begin : g_sync
        btn_sync u_sync (
            .ck    (ck),
            .reset (reset),
            .d     (button[g]),
            .q     (bsync_s[g])
        );
    end

    assign mismatch_s = bsync_s ^ level_r;
    assign pick_s     = rr_pick(mismatch_s, ptr_r);

    // Scan / settle / report FSM with the shared counter and registered outputs
    always_ff @(posedge ck) begin
        if (reset) begin
            state_r <= ST_SCAN;
            ptr_r   <= '0;
            sel_r   <= '0;
            cand_r  <= 1'b0;
            cnt_r   <= '0;
            level_r <= '0;
            push_r  <= '0;
        end else begin
            push_r <= '0;
            case (state_r)
                ST_SCAN: begin
                    if (mismatch_s != '0) begin
                        sel_r   <= pick_s;
                        cand_r  <= bsync_s[pick_s];
                        cnt_r   <= '0;
                        state_r <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Advancing ptr on abort keeps a bouncing button from starving the rest
                    if (bsync_s[sel_r] != cand_r) begin
                        ptr_r   <= next_idx(sel_r);
                        state_r <= ST_SCAN;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_REPORT;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    level_r[sel_r] <= cand_r;
                    push_r[sel_r]  <= cand_r;
                    ptr_r          <= next_idx(sel_r);
                    state_r        <= ST_SCAN;
                end
                default: begin
                    state_r <= ST_SCAN;
                end
            endcase
        end
    end

    assign push  = push_r;
    assign level = level_r;
    assign busy  = (state_r != ST_SCAN);

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl at default parameters (4 buttons, 8 stable cycles).
module tb_debounce_scan_ctrl;

    logic       ck;
    logic       reset;
    logic [3:0] button;
    logic [3:0] push;
    logic [3:0] level;
    logic       busy;

    int n_cmp;
    int n_err;

    debounce_scan_ctrl dut (
        .ck     (ck),
        .reset  (reset),
        .button (button),
        .push   (push),
        .level  (level),
        .busy   (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        button = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (push !== 4'b0000) begin n_err++; $display("FAIL reset_push: got %b want 0000", push); end
            n_cmp++;
            if (level !== 4'b0000) begin n_err++; $display("FAIL reset_level: got %b want 0000", level); end
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        end
        button = 4'b0000;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
        end
    endtask

    // Press at edge E0 must pulse exactly at E0+11 (tick 12); release gives no pulse
    task automatic test_clean_press();
        logic [3:0] ep;
        logic [3:0] el;
        button = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            tick();
            ep = (k == 12) ? 4'b0001 : 4'b0000;
            el = (k >= 12) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (push !== ep) begin n_err++; $display("FAIL press_push k=%0d: got %b want %b", k, push, ep); end
            n_cmp++;
            if (level !== el) begin n_err++; $display("FAIL press_level k=%0d: got %b want %b", k, level, el); end
        end
        button = 4'b0000;
        for (int k = 1; k <= 14; k++) begin
            tick();
            el = (k >= 12) ? 4'b0000 : 4'b0001;
            n_cmp++;
            if (push !== 4'b0000) begin n_err++; $display("FAIL release_push k=%0d: got %b want 0000", k, push); end
            n_cmp++;
            if (level !== el) begin n_err++; $display("FAIL release_level k=%0d: got %b want %b", k, level, el); end
        end
    endtask

    task automatic test_bounce();
        int pulses;
        logic [3:0] ep;
        button[1] = 1'b1; #1;
        button[1] = 1'b0; #1;
        button[1] = 1'b1; #1;
        button[1] = 1'b0; #1;
        button[1] = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            ep = (k == 12) ? 4'b0010 : 4'b0000;
            if (push != 4'b0000) pulses++;
            n_cmp++;
            if (push !== ep) begin n_err++; $display("FAIL bounce_push k=%0d: got %b want %b", k, push, ep); end
        end
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL bounce_pulses: got %0d want 1", pulses); end
        n_cmp++;
        if (level !== 4'b0010) begin n_err++; $display("FAIL bounce_level: got %b want 0010", level); end
        button[1] = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (push != 4'b0000) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL bounce_release_pulses: got %0d want 0", pulses); end
        n_cmp++;
        if (level !== 4'b0000) begin n_err++; $display("FAIL bounce_release_level: got %b want 0000", level); end
    endtask

    // ptr=0 after reset, so button 2 wins first and button 3 follows 10 clocks later
    task automatic test_contention();
        logic [3:0] ep;
        do_reset(2);
        button = 4'b1100;
        for (int k = 1; k <= 26; k++) begin
            tick();
            ep = (k == 12) ? 4'b0100 : ((k == 22) ? 4'b1000 : 4'b0000);
            n_cmp++;
            if (push !== ep) begin n_err++; $display("FAIL contention_push k=%0d: got %b want %b", k, push, ep); end
        end
        n_cmp++;
        if (level !== 4'b1100) begin n_err++; $display("FAIL contention_level: got %b want 1100", level); end
        button = 4'b0000;
        for (int k = 1; k <= 30; k++) tick();
        n_cmp++;
        if (level !== 4'b0000) begin n_err++; $display("FAIL contention_release_level: got %b want 0000", level); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL contention_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        int pulses;
        button[0] = 1'b1;
        tick(); tick(); tick();
        button[0] = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (push != 4'b0000) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
        n_cmp++;
        if (level !== 4'b0000) begin n_err++; $display("FAIL glitch_level: got %b want 0000", level); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_settle();
        logic [3:0] ep;
        button[0] = 1'b1;
        // SETTLE is entered at E2; after E6 the FSM is four clocks into it
        for (int k = 1; k <= 7; k++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midsettle_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL midsettle_busy_reset: got %b want 0", busy); end
        n_cmp++;
        if (push !== 4'b0000) begin n_err++; $display("FAIL midsettle_push_reset: got %b want 0000", push); end
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            ep = (k == 12) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (push !== ep) begin n_err++; $display("FAIL midsettle_push k=%0d: got %b want %b", k, push, ep); end
        end
        n_cmp++;
        if (level !== 4'b0001) begin n_err++; $display("FAIL midsettle_level: got %b want 0001", level); end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        button = 4'b0000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_contention();
        test_glitch();
        test_reset_mid_settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
